div_seq_rsp: RTL and testbench
==============================

// Module: div_seq_rsp
// PURPOSE
//  Sequential restoring divider that answers the ALU's one-hot init handshake
//  for opcode 2'b11: the ALU initiates, this block responds.
//  Captures dividend/divisor on an init rising edge and runs one quotient bit per clock.
//  Returns quotient, remainder, a one-cycle done pulse and a divide-by-zero flag.
//  The quotient feeds the ALU result mux toward the BCD/seven-segment display.
// PARAMETERS
//  WIDTH  3  operand, quotient and remainder width in bits (WIDTH >= 2)
// PORTS
//  clk      in   1      system clock, rising-edge active
//  rst      in   1      asynchronous reset, active-high
//  init     in   1      level request from ALU opcode decode; a start is its 0->1 transition
//  Divdo    in   WIDTH  dividend, unsigned
//  divor    in   WIDTH  divisor, unsigned
//  ResultD  out  WIDTH  quotient, registered, held until next completion
//  Resto    out  WIDTH  remainder, registered, held until next completion
//  busy     out  1      high while an operation is in progress (state != IDLE)
//  done     out  1      one-cycle pulse: ResultD/Resto/dz valid and newly updated
//  dz       out  1      divide-by-zero flag for the last completed operation
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; iteration counter 0; init_q (init delay flop) 0.
//  Start detection: start = init & ~init_q, sampled at a rising clk edge (t0).
//   init held high across reset release gives exactly one start.
//   init held high for many cycles gives one start only.
//  FSM states: IDLE, CALC, FIN.
//   IDLE: on start at t0, latch Divdo into Q, divor into D, R <= 0, cnt <= 0.
//     divor == 0: go to FIN. Otherwise go to CALC. busy rises after t0.
//   CALC: each edge performs one iteration.
//     Rs = {R, Q[WIDTH-1]}, which is WIDTH+1 bits.
//     If Rs >= D: R <= Rs - D and shift 1 into Q. Else R <= Rs and shift 0 into Q.
//     Q shifts left. cnt increments.
//     On the edge where cnt == WIDTH-1 (edge t0+WIDTH): write ResultD/Resto from the final values,
//     set dz <= 0 and done <= 1, and go to IDLE.
//   FIN (divide by zero): at edge t0+1, ResultD <= all ones, Resto <= dividend,
//     dz <= 1, done <= 1, go to IDLE.
//  Latency: done high in the cycle after edge t0+WIDTH (normal) or t0+1 (divide by zero).
//   done lasts exactly one cycle. busy is 0 in the done cycle.
//  Start edges while busy are ignored (init_q still tracks init), with no effect on the running operation.
//  A start coincident with the done cycle is accepted (state is IDLE).
//  Outputs are stable between completions. dz is updated only at completion.
//  Asynchronous rst mid-operation: immediate return to the reset state.
//   No done pulse; prior results are lost.
//  Arithmetic: unsigned. R never exceeds D-1 after an iteration, so Resto fits in WIDTH bits.
// TESTING
//  1. Reset with init=0, then Divdo=7, divor=2, init 0->1 -> done after 3 edges; ResultD=3, Resto=1, dz=0.
//  2. Divdo=5, divor=0, start -> done after 1 edge; ResultD=7, Resto=5, dz=1; next op 6/3 -> Q=2, R=0, dz=0.
//  3. Divdo=2, divor=7 -> Q=0, R=2. Then Divdo=7, divor=1 -> Q=7, R=0.
//     Exhaustive sweep of all 64 pairs against a reference model.
//  4. init held high for 20 cycles with operands changed mid-way -> exactly one done; result uses operands from t0.
//  5. Re-pulse init during CALC -> ignored, single done. Start on the done cycle -> second op completes WIDTH edges later.
//  6. Assert rst during CALC -> busy=done=dz=ResultD=Resto=0 immediately; no done pulse.
//     init high at rst release -> one new operation.

Source files
------------

// File: rtl/div_seq_rsp.sv
// -----------------------------------------------------------------------------
// div_seq_rsp
//   Sequential restoring divider that responds to the ALU's init handshake
//   for the divide opcode. A 0->1 transition on init captures the operands.
//   One quotient bit is then produced per clock. The block returns the quotient,
//   the remainder, a one-cycle done pulse and a divide-by-zero flag.
//
// Ports
//   clk      in   1      system clock, rising-edge active
//   rst      in   1      asynchronous reset, active-high
//   init     in   1      level request; a start is its rising transition
//   Divdo    in   WIDTH  dividend, unsigned
//   divor    in   WIDTH  divisor, unsigned
//   ResultD  out  WIDTH  quotient, held until the next completion
//   Resto    out  WIDTH  remainder, held until the next completion
//   busy     out  1      high while an operation is in progress
//   done     out  1      one-cycle pulse when the results are newly updated
//   dz       out  1      divide-by-zero flag of the last completed operation
// -----------------------------------------------------------------------------
module div_seq_rsp #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] Divdo,
  input  logic [WIDTH-1:0] divor,
  output logic [WIDTH-1:0] ResultD,
  output logic [WIDTH-1:0] Resto,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t           state;
  logic             init_q;
  logic [WIDTH-1:0] q;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d;        // latched divisor
  logic [WIDTH-1:0] r;        // partial remainder
  logic [CW-1:0]    cnt;

  logic             start;
  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign start = init & ~init_q;

  // One restoring step. When Rs >= D the true difference is below D, so it
  // fits in WIDTH bits and modulo-2^WIDTH subtraction of the low bits is exact.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    rs     = {r, q[WIDTH-1]};
    ge     = (rs >= {1'b0, d});
    r_next = ge ? (rs[WIDTH-1:0] - d) : rs[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ge};
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      init_q  <= 1'b0;
      q       <= '0;
      d       <= '0;
      r       <= '0;
      cnt     <= '0;
      ResultD <= '0;
      Resto   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      // init_q tracks init in every state. This lets a start edge that arrives
      // while busy be consumed silently.
      init_q <= init;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q     <= Divdo;
            d     <= divor;
            r     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (divor == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          q   <= q_next;
          r   <= r_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            ResultD <= q_next;
            Resto   <= r_next;
            dz      <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        FIN: begin
          // Divide by zero. The quotient saturates and the dividend is returned as the remainder.
          ResultD <= '1;
          Resto   <= q;
          dz      <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_rsp.sv
module tb_div_seq_rsp;

  localparam int W = 3;
  localparam int BUDGET = 12;

  logic         clk;
  logic         rst;
  logic         init;
  logic [W-1:0] Divdo;
  logic [W-1:0] divor;
  logic [W-1:0] ResultD;
  logic [W-1:0] Resto;
  logic         busy;
  logic         done;
  logic         dz;

  int checks   = 0;
  int failures = 0;

  div_seq_rsp #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .Divdo   (Divdo),
    .divor   (divor),
    .ResultD (ResultD),
    .Resto   (Resto),
    .busy    (busy),
    .done    (done),
    .dz      (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain unsigned arithmetic.
  // Latency is the number of edges from the start edge to the completion edge.
  task automatic ref_div(input int a, input int b,
                         output int q, output int r, output int z, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; z = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 0; lat = W;
    end
  endtask

  // Stimulus helper. It is called about 1 time unit after a rising edge.
  // It drops init for one edge, then raises init with the operands applied.
  // It then counts edges until done is seen. n == 1 is the start edge t0.
  // The helper also reports busy after t0, busy in the done cycle, and done one cycle later.
  task automatic start_wait(input int a, input int b,
                            output int n, output int qo, output int ro, output int zo,
                            output logic busy_t0, output logic busy_dn, output logic done_nx);
    init = 1'b0;
    @(posedge clk); #1;
    Divdo = W'(a);
    divor = W'(b);
    init  = 1'b1;
    n = 0; busy_t0 = 1'b0; busy_dn = 1'b1;
    qo = -1; ro = -1; zo = -1;
    while (n <= BUDGET) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) busy_t0 = busy;
      if (done) begin
        qo = int'(ResultD); ro = int'(Resto); zo = int'(dz); busy_dn = busy;
        break;
      end
    end
    init = 1'b0;
    @(posedge clk); #1;
    done_nx = done;
  endtask

  // One operation checked against the model.
  task automatic run_and_check(input string tag, input int a, input int b);
    int n, qo, ro, zo, eq, er, ez, el;
    logic bt, bd, dn;
    ref_div(a, b, eq, er, ez, el);
    start_wait(a, b, n, qo, ro, zo, bt, bd, dn);
    checks++;
    if (n !== el + 1 || qo !== eq || ro !== er || zo !== ez || bt !== 1'b1 || bd !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL %s %0d/%0d: got edges=%0d q=%0d r=%0d dz=%0d busy_t0=%b busy_done=%b done_next=%b; expected edges=%0d q=%0d r=%0d dz=%0d busy_t0=1 busy_done=0 done_next=0",
               tag, a, b, n, qo, ro, zo, bt, bd, dn, el + 1, eq, er, ez);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; Divdo = '0; divor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ResultD, Resto, busy, done, dz} !== '0) begin
      failures++;
      $display("FAIL reset_state: got q=%0d r=%0d busy=%b done=%b dz=%b; expected all 0", ResultD, Resto, busy, done, dz);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b; expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_and_check("basic", 7, 2);
  endtask

  task automatic test_div_zero();
    run_and_check("div_zero", 5, 0);
    run_and_check("after_dz", 6, 3);
  endtask

  task automatic test_boundaries();
    run_and_check("small_dividend", 2, 7);
    run_and_check("divide_by_one", 7, 1);
    run_and_check("zero_by_zero", 0, 0);
    run_and_check("max_by_max", 7, 7);
  endtask

  task automatic test_sweep();
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        run_and_check("sweep", a, b);
    for (int i = 0; i < 30; i++)
      run_and_check("random", int'($urandom_range((1 << W) - 1)), int'($urandom_range((1 << W) - 1)));
  endtask

  task automatic test_init_held();
    int dones, qo, ro;
    init = 1'b0;
    @(posedge clk); #1;
    Divdo = 3'd6; divor = 3'd4; init = 1'b1;
    dones = 0; qo = -1; ro = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin Divdo = 3'd1; divor = 3'd1; end
      if (done) begin dones++; qo = int'(ResultD); ro = int'(Resto); end
    end
    init = 1'b0;
    checks++;
    if (dones !== 1 || qo !== 1 || ro !== 2) begin
      failures++;
      $display("FAIL init_held: got dones=%0d q=%0d r=%0d; expected dones=1 q=1 r=2", dones, qo, ro);
    end
  endtask

  task automatic test_back_to_back();
    int dones, qo, ro, n, q1, r1;
    // A start edge during CALC must be ignored.
    init = 1'b0;
    @(posedge clk); #1;
    Divdo = 3'd7; divor = 3'd3; init = 1'b1;
    dones = 0; qo = -1; ro = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) init = 1'b0;
      if (i == 2) init = 1'b1;
      if (done) begin dones++; qo = int'(ResultD); ro = int'(Resto); end
    end
    init = 1'b0;
    checks++;
    if (dones !== 1 || qo !== 2 || ro !== 1) begin
      failures++;
      $display("FAIL repulse_ignored: got dones=%0d q=%0d r=%0d; expected dones=1 q=2 r=1", dones, qo, ro);
    end

    // A start raised in the done cycle must be accepted at the following edge.
    @(posedge clk); #1;
    Divdo = 3'd5; divor = 3'd2; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    n = 1; q1 = -1; r1 = -1;
    while (!done && n <= BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    if (done) begin q1 = int'(ResultD); r1 = int'(Resto); end
    Divdo = 3'd6; divor = 3'd4; init = 1'b1;
    checks++;
    if (n !== W + 1 || q1 !== 2 || r1 !== 1) begin
      failures++;
      $display("FAIL first_of_pair: got edges=%0d q=%0d r=%0d; expected edges=%0d q=2 r=1", n, q1, r1, W + 1);
    end
    n = 0; qo = -1; ro = -1;
    while (n <= BUDGET) begin
      @(posedge clk); #1;
      n++;
      if (done) begin qo = int'(ResultD); ro = int'(Resto); break; end
    end
    init = 1'b0;
    checks++;
    if (n !== W + 1 || qo !== 1 || ro !== 2) begin
      failures++;
      $display("FAIL start_on_done: got edges=%0d q=%0d r=%0d; expected edges=%0d q=1 r=2", n, qo, ro, W + 1);
    end
  endtask

  task automatic test_rst_mid();
    int n, qo, ro;
    logic saw_done;
    run_and_check("pre_rst", 7, 2);
    @(posedge clk); #1;
    Divdo = 3'd7; divor = 3'd3; init = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({ResultD, Resto, busy, done, dz} !== '0) begin
      failures++;
      $display("FAIL rst_mid_calc: got q=%0d r=%0d busy=%b done=%b dz=%b; expected all 0", ResultD, Resto, busy, done, dz);
    end
    saw_done = 1'b0;
    Divdo = 3'd5; divor = 3'd3;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk); rst = 1'b0;
    n = 0; qo = -1; ro = -1;
    while (n <= BUDGET) begin
      @(posedge clk); #1;
      n++;
      if (done) begin qo = int'(ResultD); ro = int'(Resto); break; end
    end
    init = 1'b0;
    checks++;
    if (saw_done !== 1'b0 || n !== W + 1 || qo !== 1 || ro !== 2) begin
      failures++;
      $display("FAIL rst_release_start: got done_in_rst=%b edges=%0d q=%0d r=%0d; expected done_in_rst=0 edges=%0d q=1 r=2",
               saw_done, n, qo, ro, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_sweep();
    test_init_held();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
